// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller front end: default sizing
// constants, per-direction indexing and a small width helper.
package traffic_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int WAIT_W_DEF          = 8;

  // Index into per-direction arrays
  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  // Width of a counter that must reach cycles-1; never narrower than 1 bit
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a persistence filter. The stable level
// only follows the synchronized input after it has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; any return to the stable level in
// between restarts the count, so short glitches never reach the output.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync2;
  logic [CNT_W-1:0] cnt_q;

  assign sync2 = sync_q[1];

  // Bring the asynchronous sensor into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Count consecutive mismatch cycles; adopt the new level on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q  <= '0;
      stable <= sync2;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vehicle_request_conditioner.sv
// Turns bouncy loop-sensor inputs into latched per-direction service
// requests that hold until that direction goes green, and tracks how long
// each request has waited so a later stage can favour the longest waiter.
module vehicle_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int WAIT_W          = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ns_sensor_raw,
  input  logic              ew_sensor_raw,
  input  logic              ns_green,
  input  logic              ew_green,
  output logic              ns_vehicle_detect,
  output logic              ew_vehicle_detect,
  output logic [WAIT_W-1:0] ns_wait_cnt,
  output logic [WAIT_W-1:0] ew_wait_cnt,
  output logic              ns_wait_sat,
  output logic              ew_wait_sat,
  output logic              ns_priority
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  logic [1:0]        raw;
  logic [1:0]        green;
  logic [1:0]        stable;
  logic [1:0]        req_q;
  logic [WAIT_W-1:0] wait_q [2];

  assign raw[DIR_NS]   = ns_sensor_raw;
  assign raw[DIR_EW]   = ew_sensor_raw;
  assign green[DIR_NS] = ns_green;
  assign green[DIR_EW] = ew_green;

  for (genvar d = 0; d < 2; d++) begin : g_dir
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[d]),
      .stable(stable[d])
    );
  end

  // Request latch: being served clears it and wins over a present vehicle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 2'b00;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (green[d]) begin
          req_q[d] <= 1'b0;
        end else if (stable[d]) begin
          req_q[d] <= 1'b1;
        end
      end
    end
  end

  // Saturating wait counters; they hold while green is up with the request
  // still set, and clear once the request is gone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q[0] <= '0;
      wait_q[1] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!req_q[d]) begin
          wait_q[d] <= '0;
        end else if (!green[d] && (wait_q[d] != WAIT_MAX)) begin
          wait_q[d] <= wait_q[d] + WAIT_W'(1);
        end
      end
    end
  end

  // NS wins when it is the only requester or has waited at least as long
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_priority <= 1'b0;
    end else begin
      ns_priority <= req_q[DIR_NS] &
                     (~req_q[DIR_EW] | (wait_q[DIR_NS] >= wait_q[DIR_EW]));
    end
  end

  assign ns_vehicle_detect = req_q[DIR_NS];
  assign ew_vehicle_detect = req_q[DIR_EW];
  assign ns_wait_cnt       = wait_q[DIR_NS];
  assign ew_wait_cnt       = wait_q[DIR_EW];
  assign ns_wait_sat       = (wait_q[DIR_NS] == WAIT_MAX);
  assign ew_wait_sat       = (wait_q[DIR_EW] == WAIT_MAX);

endmodule

// File: doc/vehicle_request_conditioner.md
Name: vehicle_request_conditioner

Overview:
- Upstream stage of the Traffic controller core; produces its NS_VEHICLE_DETECT / EW_VEHICLE_DETECT inputs.
- Converts raw, asynchronous, bouncy loop-sensor inputs into clean, latched per-direction service requests held until that direction is served (green).
- Also tracks per-direction wait time and flags which direction has waited longest, for a later fairness/priority stage.

Parameters:
- DEBOUNCE_CYCLES, 8: consecutive cycles a synchronized sensor level must persist before the stable level changes; legal range >= 1.
- WAIT_W, 8: width of each wait counter; counters saturate at 2^WAIT_W-1.

Ports:
- clk  input  1  system clock; same clk that drives the nsCounter/ewCounter/yellowCounter timers.
- rst_n  input  1  asynchronous, active-low reset.
- ns_sensor_raw  input  1  raw NS loop sensor; asynchronous to clk, may bounce.
- ew_sensor_raw  input  1  raw EW loop sensor; asynchronous to clk, may bounce.
- ns_green  input  1  NS_GREEN fed back from the Traffic core; marks NS as being served.
- ew_green  input  1  EW_GREEN fed back from the Traffic core.
- ns_vehicle_detect  output  1  latched NS request; drives the core's NS_VEHICLE_DETECT.
- ew_vehicle_detect  output  1  latched EW request; drives the core's EW_VEHICLE_DETECT.
- ns_wait_cnt  output  WAIT_W  cycles the NS request has waited unserved.
- ew_wait_cnt  output  WAIT_W  cycles the EW request has waited unserved.
- ns_wait_sat  output  1  ns_wait_cnt is at all-ones.
- ew_wait_sat  output  1  ew_wait_cnt is at all-ones.
- ns_priority  output  1  NS has a pending request and has waited at least as long as EW.

Behaviour:
- Reset (async assert, sync release): all flops and all outputs go to 0, including synchronizers, debounce counters and stable levels.
- Synchronizer: each raw input passes through a 2-flop synchronizer (sync2). No other logic touches the raw inputs.
- Debounce, per direction:
  - Holds a stable level and a counter.
  - While sync2 == stable: counter = 0.
  - While sync2 != stable: counter increments.
  - When counter reaches DEBOUNCE_CYCLES-1 and the mismatch is still present: stable <= sync2 and counter <= 0 in the same cycle.
  - Any single-cycle return to the stable level resets the counter (a glitch shorter than DEBOUNCE_CYCLES never propagates).
- Request latch, per direction, evaluated every cycle:
  - green == 1: req <= 0. Served has priority over set.
  - else stable == 1: req <= 1.
  - otherwise: req holds.
  - The request persists after the vehicle leaves (stable falls) until green is seen.
  - A vehicle still present when green drops re-requests on the next cycle.
- Latency: raw rising edge held steady -> vehicle_detect high after 2 + DEBOUNCE_CYCLES + 1 clk edges.
- Wait counter, per direction:
  - req == 1 and green == 0: count <= count + 1, saturating at all-ones (no wrap).
  - req == 0: count <= 0.
  - wait_sat is combinational: count == all-ones.
- Priority:
  - Registered: ns_priority <= ns_req & (!ew_req | ns_wait_cnt >= ew_wait_cnt), evaluated on the current-cycle registered values.
  - Ties go to NS.
  - 0 when ns_req == 0.
- Simultaneous events:
  - Both directions are independent; both requests and both counters may be active at once.
  - ns_green and ew_green both high is illegal upstream behaviour; the block still clears both requests with no other special handling.
- Reset mid-operation: immediate clear of every request, counter and stable level. A sensor still held high after release re-requests after the full debounce latency.

Decomposition:
- Shared package traffic_pkg:
  - DEBOUNCE_CYCLES_DEF = 8 and WAIT_W_DEF = 8 constants.
  - A dir_e typedef {DIR_NS, DIR_EW} for indexing per-direction arrays.
- One natural sub-module, sensor_debounce (sync2 + debounce counter + stable level), parameterized by DEBOUNCE_CYCLES and instantiated once per direction.
- Request latch, wait counters and priority logic stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, WAIT_W=4):
- Reset then ns_sensor_raw held 1, greens 0 -> ns_vehicle_detect rises exactly 7 clk edges after the first sampling edge; ns_wait_cnt counts 1,2,... and saturates at 15 with ns_wait_sat=1.
- ew_sensor_raw pulsed high for 3 cycles, repeated with 1-cycle low gaps -> ew_vehicle_detect stays 0 for the whole run.
- NS request latched, sensor drops to 0, ns_green asserted 1 cycle later -> ns_vehicle_detect stays 1 until ns_green, clears on the next edge, ns_wait_cnt returns to 0.
- Both requests pending with ns_wait_cnt=5 and ew_wait_cnt=9 -> ns_priority=0; after ew_green clears EW -> ns_priority=1 the following cycle. Equal counts -> ns_priority=1.
- Sensor held 1 through a full green interval -> request is 0 during green and re-asserts 1 cycle after green falls; wait counter restarts from 0.
- rst_n pulsed low mid-wait with ns_wait_cnt=6 -> all outputs 0 asynchronously; held sensor re-requests 7 edges after release.
